// File: rtl/dcache_ctrl.sv
// Miss-handling controller for a 4-way write-back data cache: lookup, dirty
// write-back, allocate/refill sequencing, plus saturating hit/miss/wb counters.
module dcache_ctrl #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 i_clk,
   input  logic                 i_arst,
   input  logic                 i_req,
   input  logic                 i_we,
   input  logic                 i_hit,
   input  logic                 i_dirty,
   input  logic                 i_mem_wr_done,
   input  logic                 i_mem_rd_done,
   input  logic                 i_cnt_clr,
   output logic                 o_stall,
   output logic                 o_mem_access,
   output logic                 o_write_en,
   output logic                 o_block_we,
   output logic                 o_addr_sel,
   output logic                 o_mem_wr_req,
   output logic                 o_mem_rd_req,
   output logic [CNT_WIDTH-1:0] o_hit_cnt,
   output logic [CNT_WIDTH-1:0] o_miss_cnt,
   output logic [CNT_WIDTH-1:0] o_wb_cnt
);

   typedef enum logic [1:0] {
      LOOKUP    = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2,
      REFILL    = 2'd3
   } state_t;

   state_t state, state_next;

   logic hit_evt, miss_evt, wb_evt;

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) state <= LOOKUP;
      else        state <= state_next;
   end

   // Memory handshake: o_mem_*_req is a level held until the matching
   // one-cycle *_done strobe; a strobe arriving in any other state is ignored.
   always_comb begin
      state_next   = state;
      o_stall      = 1'b0;
      o_mem_access = 1'b0;
      o_write_en   = 1'b0;
      o_block_we   = 1'b0;
      o_addr_sel   = 1'b0;
      o_mem_wr_req = 1'b0;
      o_mem_rd_req = 1'b0;
      case (state)
         LOOKUP: begin
            o_mem_access = i_req;
            o_write_en   = i_req & i_we;
            o_stall      = i_req & ~i_hit;
            if (i_req && !i_hit) state_next = i_dirty ? WRITEBACK : ALLOCATE;
         end
         WRITEBACK: begin
            o_mem_wr_req = 1'b1;
            o_addr_sel   = 1'b1;
            o_stall      = 1'b1;
            if (i_mem_wr_done) state_next = ALLOCATE;
         end
         ALLOCATE: begin
            o_mem_rd_req = 1'b1;
            o_stall      = 1'b1;
            if (i_mem_rd_done) state_next = REFILL;
         end
         REFILL: begin
            o_block_we = 1'b1;
            o_stall    = 1'b1;
            state_next = LOOKUP;
         end
         default: state_next = LOOKUP;
      endcase
      // Outputs are forced low for the whole reset pulse, not just after the edge.
      if (i_arst) begin
         o_stall      = 1'b0;
         o_mem_access = 1'b0;
         o_write_en   = 1'b0;
         o_block_we   = 1'b0;
         o_addr_sel   = 1'b0;
         o_mem_wr_req = 1'b0;
         o_mem_rd_req = 1'b0;
      end
   end

   assign hit_evt  = (state == LOOKUP) & i_req & i_hit;
   assign miss_evt = (state == LOOKUP) & i_req & ~i_hit;
   assign wb_evt   = miss_evt & i_dirty;

   function automatic logic [CNT_WIDTH-1:0] sat_next(
      input logic [CNT_WIDTH-1:0] cnt,
      input logic                 inc,
      input logic                 clr
   );
      if (clr) return '0;
      if (inc && (cnt != '1)) return cnt + CNT_WIDTH'(1);
      return cnt;
   endfunction

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         o_hit_cnt  <= '0;
         o_miss_cnt <= '0;
         o_wb_cnt   <= '0;
      end else begin
         o_hit_cnt  <= sat_next(o_hit_cnt,  hit_evt,  i_cnt_clr);
         o_miss_cnt <= sat_next(o_miss_cnt, miss_evt, i_cnt_clr);
         o_wb_cnt   <= sat_next(o_wb_cnt,   wb_evt,   i_cnt_clr);
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed miss/reset/saturation scenarios plus random
// traffic, all checked every cycle against a transaction-level miss model.
module tb_dcache_ctrl;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          arst = 1'b0;
   logic          req = 1'b0, we = 1'b0, hit = 1'b0, dirty = 1'b0;
   logic          wr_done = 1'b0, rd_done = 1'b0, cnt_clr = 1'b0;
   logic          stall, mem_access, write_en, block_we, addr_sel, mem_wr_req, mem_rd_req;
   logic [CW-1:0] hit_cnt, miss_cnt, wb_cnt;

   int n_vec = 0;
   int n_err = 0;

   dcache_ctrl #(.CNT_WIDTH(CW)) dut (
      .i_clk(clk), .i_arst(arst), .i_req(req), .i_we(we), .i_hit(hit),
      .i_dirty(dirty), .i_mem_wr_done(wr_done), .i_mem_rd_done(rd_done),
      .i_cnt_clr(cnt_clr), .o_stall(stall), .o_mem_access(mem_access),
      .o_write_en(write_en), .o_block_we(block_we), .o_addr_sel(addr_sel),
      .o_mem_wr_req(mem_wr_req), .o_mem_rd_req(mem_rd_req),
      .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt), .o_wb_cnt(wb_cnt)
   );

   always #5 clk = ~clk;

   function automatic void chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void chkc(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Miss model: a miss is a pending transaction with an optional write-back
   // leg, a refill leg, and a single fill cycle.
   bit m_wb_wait, m_rd_wait, m_fill;
   int m_hit, m_miss, m_wb;

   function automatic int sat(input int c, input bit inc, input bit clr);
      if (clr) return 0;
      if (inc && c < (1 << CW) - 1) return c + 1;
      return c;
   endfunction

   always @(posedge clk or posedge arst) begin
      bit idle, hit_ev, miss_ev;
      if (arst) begin
         m_wb_wait = 0; m_rd_wait = 0; m_fill = 0;
         m_hit = 0; m_miss = 0; m_wb = 0;
      end else begin
         idle    = !(m_wb_wait || m_rd_wait || m_fill);
         hit_ev  = idle && req && hit;
         miss_ev = idle && req && !hit;
         m_hit   = sat(m_hit,  hit_ev,  cnt_clr);
         m_miss  = sat(m_miss, miss_ev, cnt_clr);
         m_wb    = sat(m_wb,   miss_ev && dirty, cnt_clr);
         if (m_fill) m_fill = 0;
         else if (m_rd_wait) begin
            if (rd_done) begin m_rd_wait = 0; m_fill = 1; end
         end else if (m_wb_wait) begin
            if (wr_done) begin m_wb_wait = 0; m_rd_wait = 1; end
         end else if (miss_ev) begin
            if (dirty) m_wb_wait = 1;
            else       m_rd_wait = 1;
         end
      end
   end

   // Observation tallies used by the directed scenarios.
   int obs_wr, obs_rd, obs_bwe, obs_store;

   always @(negedge clk) begin
      logic e_stall, e_acc, e_we, e_bwe, e_sel, e_wr, e_rd;
      bit idle;
      idle = !(m_wb_wait || m_rd_wait || m_fill);
      e_acc = 0; e_we = 0; e_stall = 0; e_bwe = 0; e_sel = 0; e_wr = 0; e_rd = 0;
      if (!arst) begin
         if (idle) begin
            e_acc = req; e_we = req & we; e_stall = req & ~hit;
         end else begin
            e_stall = 1;
            e_wr  = m_wb_wait; e_sel = m_wb_wait;
            e_rd  = m_rd_wait;
            e_bwe = m_fill;
         end
      end
      chk1("stall",      stall,      e_stall);
      chk1("mem_access", mem_access, e_acc);
      chk1("write_en",   write_en,   e_we);
      chk1("block_we",   block_we,   e_bwe);
      chk1("addr_sel",   addr_sel,   e_sel);
      chk1("mem_wr_req", mem_wr_req, e_wr);
      chk1("mem_rd_req", mem_rd_req, e_rd);
      chkc("hit_cnt",    hit_cnt,    CW'(m_hit));
      chkc("miss_cnt",   miss_cnt,   CW'(m_miss));
      chkc("wb_cnt",     wb_cnt,     CW'(m_wb));
      if (mem_wr_req) obs_wr++;
      if (mem_rd_req) obs_rd++;
      if (block_we) obs_bwe++;
      if (write_en && hit) obs_store++;
   end

   task automatic step(input logic r, input logic w, input logic h, input logic d,
                       input logic wd, input logic rdn, input logic clr);
      req = r; we = w; hit = h; dirty = d; wr_done = wd; rd_done = rdn; cnt_clr = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_clr();
      step(0, 0, 0, 0, 0, 0, 1);
      obs_wr = 0; obs_rd = 0; obs_bwe = 0; obs_store = 0;
   endtask

   initial begin
      // Reset asserted with a pending miss on the inputs: outputs must stay low.
      req = 1; hit = 0;
      #1 arst = 1;
      repeat (2) @(posedge clk);
      #1 arst = 0;

      // Load hit right after reset.
      step(1, 0, 1, 0, 0, 0, 0);
      chkc("lit_hit_after_hit", hit_cnt, 4'd1);

      // Clean load miss, refill after 5 cycles, then replay hit.
      idle_clr();
      step(1, 0, 0, 0, 0, 0, 0);
      repeat (4) step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0, 0);
      chkc("lit_clean_rd_cycles", CW'(obs_rd), 4'd5);
      chkc("lit_clean_bwe",       CW'(obs_bwe), 4'd1);
      chkc("lit_clean_miss",      miss_cnt, 4'd1);
      chkc("lit_clean_hit",       hit_cnt, 4'd1);
      chkc("lit_clean_wb",        wb_cnt, 4'd0);

      // Dirty store miss with stray strobes in both wait phases.
      idle_clr();
      step(1, 1, 0, 1, 0, 0, 0);
      step(1, 1, 0, 1, 0, 1, 0);
      step(1, 1, 0, 1, 0, 0, 0);
      step(1, 1, 0, 1, 1, 0, 0);
      step(1, 1, 0, 0, 1, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 1, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0);
      chkc("lit_dirty_wr_cycles", CW'(obs_wr), 4'd3);
      chkc("lit_dirty_rd_cycles", CW'(obs_rd), 4'd4);
      chkc("lit_dirty_bwe",       CW'(obs_bwe), 4'd1);
      chkc("lit_dirty_store",     CW'(obs_store), 4'd1);
      chkc("lit_dirty_wb",        wb_cnt, 4'd1);
      chkc("lit_dirty_miss",      miss_cnt, 4'd1);

      // Request dropped during ALLOCATE: fill still completes.
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk1("lit_drop_back_idle", stall, 1'b0);

      // Reset pulse during ALLOCATE.
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      arst = 1;
      #1;
      chk1("lit_arst_rd_req", mem_rd_req, 1'b0);
      chk1("lit_arst_stall",  stall, 1'b0);
      chkc("lit_arst_miss",   miss_cnt, 4'd0);
      @(posedge clk);
      #1 arst = 0;
      step(1, 0, 1, 0, 0, 0, 0);
      chkc("lit_arst_then_hit", hit_cnt, 4'd1);

      // Saturation and clear priority.
      idle_clr();
      repeat (16) step(1, 0, 1, 0, 0, 0, 0);
      chkc("lit_sat_15", hit_cnt, 4'd15);
      step(1, 0, 1, 0, 0, 0, 0);
      chkc("lit_sat_hold", hit_cnt, 4'd15);
      step(1, 0, 1, 0, 0, 0, 1);
      chkc("lit_clr_prio", hit_cnt, 4'd0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            arst = 1;
            #2 arst = 0;
         end
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 49) == 0);
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
